// File: rtl/display_pkg.sv
// Shared BCD display definitions: digit width, legal range, one-hot select and digit slicing helpers.
package display_pkg;

  localparam int unsigned BCD_W      = 4;
  localparam int unsigned BCD_MAX    = 9;
  localparam int unsigned MAX_DIGITS = 8;

  typedef logic [BCD_W-1:0]              bcd_t;
  typedef logic [$clog2(MAX_DIGITS)-1:0] dig_idx_t;
  typedef logic [MAX_DIGITS-1:0]         sel_t;
  typedef logic [MAX_DIGITS*BCD_W-1:0]   packed_t;

  function automatic sel_t onehot(input dig_idx_t k);
    sel_t s;
    s    = '0;
    s[k] = 1'b1;
    return s;
  endfunction

  function automatic bcd_t digit_slice(input packed_t v, input dig_idx_t k);
    return v[32'(k)*BCD_W +: BCD_W];
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Dwell counter and digit index for the display scanner; flags the last cycle of a dwell,
// the last digit of a frame, and whether the upcoming cycle falls in the blanking window.
module scan_timer
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned PRESCALE     = 1000,
  parameter int unsigned BLANK_CYCLES = 50,
  parameter int unsigned CNT_W        = $clog2(PRESCALE)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] cnt_o,
  output dig_idx_t         idx_o,
  output logic             dwell_last_o,
  output logic             frame_last_o,
  output logic             in_blank_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  dig_idx_t         idx_q, idx_d;

  always_comb begin
    dwell_last_o = (cnt_q == CNT_W'(PRESCALE - 1));
    frame_last_o = (idx_q == dig_idx_t'(NUM_DIGITS - 1));
    cnt_d        = dwell_last_o ? '0 : cnt_q + 1'b1;
    idx_d        = idx_q;
    if (dwell_last_o) begin
      idx_d = frame_last_o ? '0 : idx_q + 1'b1;
    end
    // Looks one cycle ahead so the consumer's phase register lines up with cnt_q.
    in_blank_o = (32'(cnt_d) < BLANK_CYCLES);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign cnt_o = cnt_q;
  assign idx_o = idx_q;

endmodule

// File: rtl/bcd_display_scanner.sv
// Multiplexes a packed BCD value onto one shared 7-segment decoder with frame-aligned updates.
// Optional leading-zero suppression is enabled by defining BCD_SCAN_LZ_BLANK_EN.
module bcd_display_scanner
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned PRESCALE     = 1000,
  parameter int unsigned BLANK_CYCLES = 50
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [4*NUM_DIGITS-1:0] in_data,
  output logic                    in_ready,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_start
);

  localparam int unsigned CNT_W  = $clog2(PRESCALE);
  localparam int unsigned DATA_W = NUM_DIGITS * BCD_W;

  typedef enum logic {ST_BLANK, ST_SHOW} phase_e;

  logic [CNT_W-1:0]      cnt;
  dig_idx_t              idx;
  logic                  dwell_last, frame_last, in_blank;

  logic [DATA_W-1:0]     disp_q, pend_q;
  logic                  pending_q;
  phase_e                state_q;
  bcd_t                  bcd_q;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic                  fs_q, fs_d;

  packed_t               disp_ext;
  bcd_t                  cur_digit;
  sel_t                  sel;
  logic                  legal, lz_blank, fire, boundary;

  scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .PRESCALE    (PRESCALE),
    .BLANK_CYCLES(BLANK_CYCLES),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .cnt_o       (cnt),
    .idx_o       (idx),
    .dwell_last_o(dwell_last),
    .frame_last_o(frame_last),
    .in_blank_o  (in_blank)
  );

  assign in_ready = rst_n & ~pending_q;
  assign fire     = in_valid & in_ready;
  assign boundary = dwell_last & frame_last;

  always_comb begin
    disp_ext             = '0;
    disp_ext[DATA_W-1:0] = disp_q;
    cur_digit            = digit_slice(disp_ext, idx);
    sel                  = onehot(idx);
    legal                = (cur_digit <= bcd_t'(BCD_MAX));
    lz_blank             = 1'b0;
`ifdef BCD_SCAN_LZ_BLANK_EN
    lz_blank = (idx != '0) && ((disp_ext >> (32'(idx) * BCD_W)) == '0);
`endif
    en_d = '0;
    if (state_q == ST_SHOW && legal && !lz_blank) begin
      en_d = NUM_DIGITS'(sel);
    end
    fs_d = (cnt == '0) && (idx == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp_q    <= '0;
      pend_q    <= '0;
      pending_q <= 1'b0;
      state_q   <= (BLANK_CYCLES > 0) ? ST_BLANK : ST_SHOW;
      bcd_q     <= '0;
      en_q      <= '0;
      fs_q      <= 1'b0;
    end else begin
      state_q <= in_blank ? ST_BLANK : ST_SHOW;
      bcd_q   <= cur_digit;
      en_q    <= en_d;
      fs_q    <= fs_d;
      // A handshake needs pending clear, so it can never coincide with a boundary load.
      if (fire) begin
        pend_q    <= in_data;
        pending_q <= 1'b1;
      end else if (boundary && pending_q) begin
        disp_q    <= pend_q;
        pending_q <= 1'b0;
      end
    end
  end

  assign bcd_out     = bcd_q;
  assign digit_en    = en_q;
  assign frame_start = fs_q;

endmodule
